pipe_exe_mem_skid: RTL and testbench

//  Execute->memory pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_exe_mem_skid_if.sv | 37 +++
 rtl/pipe_exe_mem_skid.sv | 49 ++++
 tb/tb_pipe_exe_mem_skid.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_exe_mem_skid_if.sv
// pipe_exe_mem_skid_if: handshake bundle between the execute stage, the EXE->MEM skid register and the memory stage
// Signals:
//   flush                  - synchronous kill of all entries
//   valid_in / ready_out   - execute-side handshake
//   *E                     - execute-side bundle fields
//   valid_out / ready_in   - memory-side handshake
//   *M                     - memory-side bundle fields
//   occ                    - number of entries held
// Modports: master drives the execute side and ready_in; slave is the pipeline register.
interface pipe_exe_mem_skid_if #(parameter int DATA_W = 32, parameter int REG_W = 4);
  logic              flush;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] ALUResultE;
  logic [DATA_W-1:0] WriteDataE;
  logic [REG_W-1:0]  WA3E;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              MemToRegE;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [REG_W-1:0]  WA3M;
  logic              RegWriteM;
  logic              MemWriteM;
  logic              MemToRegM;
  logic [1:0]        occ;
  modport master (
    output flush, valid_in, ALUResultE, WriteDataE, WA3E, RegWriteE, MemWriteE, MemToRegE, ready_in,
    input  ready_out, valid_out, ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM, occ
  );
  modport slave (
    input  flush, valid_in, ALUResultE, WriteDataE, WA3E, RegWriteE, MemWriteE, MemToRegE, ready_in,
    output ready_out, valid_out, ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM, occ
  );
endinterface

// File: rtl/pipe_exe_mem_skid.sv
// pipe_exe_mem_skid: execute->memory pipeline register with valid/ready handshake and 2-entry skid buffer
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-low reset
//   b   - slave side of pipe_exe_mem_skid_if (flush, E bundle in, M bundle out, occ)
module pipe_exe_mem_skid #(parameter int DATA_W = 32, parameter int REG_W = 4) (
  input logic clk,
  input logic rst,
  pipe_exe_mem_skid_if.slave b
);
  localparam int BW = 2*DATA_W + REG_W + 3;
  // encoding doubles as the occupancy count
  localparam logic [1:0] EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2;
  logic [1:0]    r_state, w_nxt;
  logic          r_ready;
  logic [BW-1:0] r_main, r_skid, w_in;
  logic          w_in_fire, w_out_fire, w_rw, w_mw;
  assign w_in = {b.ALUResultE, b.WriteDataE, b.WA3E, b.RegWriteE, b.MemWriteE, b.MemToRegE};
  assign w_in_fire = b.valid_in & r_ready;
  assign w_out_fire = b.valid_out & b.ready_in;
  always_comb
    w_nxt = b.flush ? EMPTY :
            r_state == EMPTY ? (w_in_fire ? BUSY : EMPTY) :
            r_state == BUSY ? ((w_in_fire & ~w_out_fire) ? FULL : (~w_in_fire & w_out_fire) ? EMPTY : BUSY) :
            (w_out_fire ? BUSY : FULL);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_nxt;
      r_ready <= w_nxt != FULL;
      if (!b.flush) begin
        if (w_in_fire & (r_state == EMPTY | w_out_fire)) r_main <= w_in;
        else if (r_state == FULL & w_out_fire) r_main <= r_skid;
        // skid content only matters once FULL is entered, so capturing every accepted beat is harmless
        if (w_in_fire) r_skid <= w_in;
      end
    end
  end
  assign b.valid_out = r_state != EMPTY;
  assign b.ready_out = r_ready;
  assign b.occ = r_state;
  assign {b.ALUResultM, b.WriteDataM, b.WA3M, w_rw, w_mw, b.MemToRegM} = r_main;
  assign b.RegWriteM = w_rw & b.valid_out;
  assign b.MemWriteM = w_mw & b.valid_out;
endmodule

// File: tb/tb_pipe_exe_mem_skid.sv
// tb_pipe_exe_mem_skid: directed and random checks of pipe_exe_mem_skid against a queue model
module tb_pipe_exe_mem_skid;
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  wa;
    logic        rw;
    logic        mw;
    logic        mtr;
  } bnd_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  bnd_t q[$];
  bnd_t last = '0;
  logic m_ready = 1'b0;
  bit cmp_en = 1'b0;
  pipe_exe_mem_skid_if #(.DATA_W(32), .REG_W(4)) b();
  pipe_exe_mem_skid #(.DATA_W(32), .REG_W(4)) dut(.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] alu, input logic rw, input logic mw,
                       input logic [3:0] wa, input logic rdy, input logic fl);
    b.valid_in = v;
    b.ALUResultE = alu;
    b.WriteDataE = ~alu;
    b.WA3E = wa;
    b.RegWriteE = rw;
    b.MemWriteE = mw;
    b.MemToRegE = alu[0];
    b.ready_in = rdy;
    b.flush = fl;
  endtask
  // capacity-2 FIFO: accept while fewer than 2 held, emit the head whenever the sink is ready
  task automatic model();
    bnd_t x;
    logic in_f, out_f;
    x = {b.ALUResultE, b.WriteDataE, b.WA3E, b.RegWriteE, b.MemWriteE, b.MemToRegE};
    if (!rst) begin
      q.delete();
      m_ready = 1'b0;
      last = '0;
    end else if (b.flush) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      in_f = b.valid_in & m_ready;
      out_f = (q.size() != 0) & b.ready_in;
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(x);
      m_ready = q.size() < 2;
    end
    if (q.size() != 0) last = q[0];
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (cmp_en) begin
      bnd_t e;
      logic v;
      v = q.size() != 0;
      e = v ? q[0] : last;
      chk("valid_out", 64'(b.valid_out), 64'(v));
      chk("occ", 64'(b.occ), 64'(q.size()));
      chk("ready_out", 64'(b.ready_out), 64'(m_ready));
      chk("ALUResultM", 64'(b.ALUResultM), 64'(e.alu));
      chk("WriteDataM", 64'(b.WriteDataM), 64'(e.wd));
      chk("WA3M", 64'(b.WA3M), 64'(e.wa));
      chk("MemToRegM", 64'(b.MemToRegM), 64'(e.mtr));
      chk("RegWriteM", 64'(b.RegWriteM), 64'(v & e.rw));
      chk("MemWriteM", 64'(b.MemWriteM), 64'(v & e.mw));
    end
  end
  initial begin
    drive(1'b1, 32'h77, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0);
    cmp_en = 1'b1;
    repeat (3) tick();
    chk("rst_occ", 64'(b.occ), 64'd0);
    chk("rst_ready", 64'(b.ready_out), 64'd0);
    chk("rst_valid", 64'(b.valid_out), 64'd0);
    chk("rst_alu", 64'(b.ALUResultM), 64'd0);
    chk("rst_mw", 64'(b.MemWriteM), 64'd0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    chk("rel_ready", 64'(b.ready_out), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
      tick();
      chk("stream_alu", 64'(b.ALUResultM), 64'(i));
      chk("stream_occ", 64'(b.occ), 64'd1);
      chk("stream_ready", 64'(b.ready_out), 64'd1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h10, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h20, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    tick();
    chk("bp_occ", 64'(b.occ), 64'd2);
    chk("bp_ready", 64'(b.ready_out), 64'd0);
    chk("bp_headA", 64'(b.ALUResultM), 64'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    chk("bp_headB", 64'(b.ALUResultM), 64'h20);
    chk("bp_ready_after", 64'(b.ready_out), 64'd1);
    tick();
    chk("bp_drained", 64'(b.valid_out), 64'd0);
    drive(1'b1, 32'h30, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h40, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
    tick();
    chk("fl_pre_occ", 64'(b.occ), 64'd2);
    drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1);
    tick();
    chk("fl_valid", 64'(b.valid_out), 64'd0);
    chk("fl_rw", 64'(b.RegWriteM), 64'd0);
    chk("fl_mw", 64'(b.MemWriteM), 64'd0);
    chk("fl_occ", 64'(b.occ), 64'd0);
    chk("fl_ready", 64'(b.ready_out), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    chk("fl_dropped", 64'(b.valid_out), 64'd0);
    drive(1'b1, 32'h55, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0);
    tick();
    chk("gate_mw1", 64'(b.MemWriteM), 64'd1);
    chk("gate_wa1", 64'(b.WA3M), 64'hA);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    chk("gate_mw0", 64'(b.MemWriteM), 64'd0);
    chk("gate_wa_hold", 64'(b.WA3M), 64'hA);
    repeat (500) begin
      drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
            4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(99) < 2));
      tick();
    end
    drive(1'b1, 32'h60, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_occ", 64'(b.occ), 64'd0);
    chk("mid_rst_ready", 64'(b.ready_out), 64'd0);
    chk("mid_rst_alu", 64'(b.ALUResultM), 64'd0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    chk("mid_rel_ready", 64'(b.ready_out), 64'd1);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
